// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response and data-memory bus for lsu_mem_ctrl.
// slave = controller side, master = core + memory side.
interface lsu_mem_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_write_en;
    logic [WIDTH-1:0] mem_write_data;
    logic [WIDTH-1:0] mem_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_write_en, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller: decode, alignment/bounds check, load extension and
// read-modify-write for SB/SH. Define LSU_STATS_EN to add load/store/error counters.
module lsu_mem_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_ctrl_if.slave    bus
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]      load_cnt,
    output logic [15:0]      store_cnt,
    output logic [15:0]      err_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW,
        S_WRITE,
        S_RESP
    } state_t;

    // Bounds are compared one bit wider so addr+3 cannot wrap past zero.
    localparam logic [WIDTH:0] LAST_ADDR = (WIDTH+1)'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] merge_q, merge_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             illegal;
    logic             misalign;
    logic             oob;
    logic [WIDTH:0]   end_addr;

    function automatic logic [WIDTH-1:0] ext_load(input logic [2:0] f3,
                                                   input logic [WIDTH-1:0] d);
        logic s;
        case (f3[1:0])
            2'd0: begin
                s = ~f3[2] & d[7];
                return {{24{s}}, d[7:0]};
            end
            2'd1: begin
                s = ~f3[2] & d[15];
                return {{16{s}}, d[15:0]};
            end
            default: return d;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] merge_store(input logic [2:0] f3,
                                                      input logic [WIDTH-1:0] old,
                                                      input logic [WIDTH-1:0] wd);
        case (f3[1:0])
            2'd0:    return {old[31:8], wd[7:0]};
            2'd1:    return {old[31:16], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    always_comb begin
        illegal  = bus.req_we ? (bus.req_funct3 > 3'd2)
                              : (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11);
        misalign = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                   (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);
        end_addr = {1'b0, bus.req_addr} + (WIDTH+1)'(3);
        oob      = end_addr > LAST_ADDR;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        // Response registers change only on the edge into RESP, so they hold between responses.
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    we_d     = bus.req_we;
                    wdata_d  = bus.req_wdata;
                    if (illegal || misalign || oob) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!bus.req_we) begin
                        state_d = S_LOAD;
                    end else if (bus.req_funct3 == 3'd2) begin
                        state_d = S_WRITE;
                        merge_d = bus.req_wdata;
                    end else begin
                        state_d = S_RMW;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = ext_load(funct3_q, bus.mem_data);
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RMW: begin
                merge_d = merge_store(funct3_q, bus.mem_data, wdata_q);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.resp_valid     = (state_q == S_RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_err       = err_q;
    assign bus.mem_addr       = (state_q == S_IDLE) ? '0 : addr_q;
    assign bus.mem_write_en   = (state_q == S_WRITE) && we_q;
    assign bus.mem_write_data = merge_q;

`ifdef LSU_STATS_EN
    logic [15:0] load_cnt_q, store_cnt_q, err_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (state_q == S_RESP) begin
            if (err_q)
                err_cnt_q <= sat_inc(err_cnt_q);
            else if (we_q)
                store_cnt_q <= sat_inc(store_cnt_q);
            else
                load_cnt_q <= sat_inc(load_cnt_q);
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-array data memory model.
module tb_lsu_mem_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [7:0] mem [0:255];

    lsu_mem_ctrl_if #(.WIDTH(32)) bus ();

`ifdef LSU_STATS_EN
    logic [15:0] load_cnt, store_cnt, err_cnt;
`endif

    lsu_mem_ctrl #(.WIDTH(32), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef LSU_STATS_EN
        ,
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational little-endian read, 4-byte write on the clock edge.
    always_comb begin
        logic [32:0] idx;
        bus.mem_data = '0;
        for (int i = 0; i < 4; i++) begin
            idx = {1'b0, bus.mem_addr} + 33'(i);
            if (idx < 33'd256)
                bus.mem_data[i*8 +: 8] = mem[idx[7:0]];
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                if ({1'b0, bus.mem_addr} + 33'(i) < 33'd256)
                    mem[bus.mem_addr[7:0] + 8'(i)] <= bus.mem_write_data[i*8 +: 8];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [21];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic do_req(input int id, input vec_t v);
        int waited;
        int lat;
        int wr_seen;
        int wr_lat;
        logic [31:0] wr_data;
        waited  = 0;
        wr_seen = 0;
        wr_lat  = 0;
        wr_data = '0;
        @(negedge clk);
        while (!bus.req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("v%0d ready", id), 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.mem_write_en) begin
                wr_seen++;
                wr_lat  = lat;
                wr_data = bus.mem_write_data;
            end
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) lat = 99;
        check($sformatf("v%0d latency", id), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d rdata", id), bus.resp_rdata, v.exp_rdata);
        check($sformatf("v%0d err", id), 32'(bus.resp_err), 32'(v.exp_err));
        check($sformatf("v%0d writes", id), 32'(wr_seen), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        if (v.we && !v.exp_err) begin
            check($sformatf("v%0d wr_lat", id), 32'(wr_lat), 32'(v.exp_lat - 1));
            check($sformatf("v%0d wr_data", id), wr_data, v.exp_wdata);
        end
        @(negedge clk);
        check($sformatf("v%0d resp_pulse", id), 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        int rv_seen;
        vec_t sv;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h80; mem[8'h11] = 8'h7F; mem[8'h12] = 8'h01; mem[8'h13] = 8'hFF;
        mem[8'h21] = 8'h11; mem[8'h22] = 8'h22; mem[8'h23] = 8'h33; mem[8'h24] = 8'h44;
        mem[8'h30] = 8'hA0; mem[8'h31] = 8'hA1; mem[8'h32] = 8'hA2; mem[8'h33] = 8'hA3;

        //          we    f3    addr          wdata         exp_rdata     err   lat  exp_wdata
        vecs[0]  = '{1'b0, 3'd0, 32'h10,       32'h0,        32'hFFFFFF80, 1'b0, 2, 32'h0};
        vecs[1]  = '{1'b0, 3'd4, 32'h10,       32'h0,        32'h00000080, 1'b0, 2, 32'h0};
        vecs[2]  = '{1'b0, 3'd1, 32'h10,       32'h0,        32'h00007F80, 1'b0, 2, 32'h0};
        vecs[3]  = '{1'b0, 3'd5, 32'h12,       32'h0,        32'h0000FF01, 1'b0, 2, 32'h0};
        vecs[4]  = '{1'b0, 3'd2, 32'h10,       32'h0,        32'hFF017F80, 1'b0, 2, 32'h0};
        vecs[5]  = '{1'b1, 3'd0, 32'h21,       32'hAABBCCDD, 32'h0,        1'b0, 3, 32'h443322DD};
        vecs[6]  = '{1'b0, 3'd4, 32'h21,       32'h0,        32'h000000DD, 1'b0, 2, 32'h0};
        vecs[7]  = '{1'b0, 3'd0, 32'h22,       32'h0,        32'h00000022, 1'b0, 2, 32'h0};
        vecs[8]  = '{1'b1, 3'd2, 32'h40,       32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 3'd2, 32'h40,       32'h0,        32'hDEADBEEF, 1'b0, 2, 32'h0};
        vecs[10] = '{1'b0, 3'd2, 32'h42,       32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[11] = '{1'b1, 3'd1, 32'h43,       32'h12345678, 32'h0,        1'b1, 1, 32'h0};
        vecs[12] = '{1'b0, 3'd2, 32'hFE,       32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[13] = '{1'b0, 3'd0, 32'hFD,       32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[14] = '{1'b0, 3'd0, 32'hFC,       32'h0,        32'h0,        1'b0, 2, 32'h0};
        vecs[15] = '{1'b0, 3'd3, 32'h10,       32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[16] = '{1'b1, 3'd4, 32'h10,       32'h1,        32'h0,        1'b1, 1, 32'h0};
        vecs[17] = '{1'b0, 3'd0, 32'hFFFFFFFE, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        vecs[18] = '{1'b1, 3'd1, 32'h52,       32'h1234ABCD, 32'h0,        1'b0, 3, 32'h0000ABCD};
        vecs[19] = '{1'b0, 3'd2, 32'h50,       32'h0,        32'hABCD0000, 1'b0, 2, 32'h0};
        vecs[20] = '{1'b0, 3'd1, 32'h52,       32'h0,        32'hFFFFABCD, 1'b0, 2, 32'h0};

        total = 0;
        bad   = 0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        rst = 1'b0;

        #2;
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_err", 32'(bus.resp_err), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst mem_write_en", 32'(bus.mem_write_en), 32'd0);
        check("rst mem_write_data", bus.mem_write_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            do_req(i, vecs[i]);
            if (i == 5) begin
                check("sb byte21", 32'(mem[8'h21]), 32'hDD);
                check("sb byte22", 32'(mem[8'h22]), 32'h22);
                check("sb byte24", 32'(mem[8'h24]), 32'h44);
            end
        end

        // Response data holds across idle cycles.
        repeat (3) @(negedge clk);
        check("hold rdata", bus.resp_rdata, 32'hFFFFABCD);
        check("hold err", 32'(bus.resp_err), 32'd0);

        // req_valid held high through a load: ignored outside IDLE.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h10;
        @(negedge clk);
        check("busy req_ready", 32'(bus.req_ready), 32'd0);
        check("busy mem_addr", bus.mem_addr, 32'h10);
        @(negedge clk);
        check("busy resp_valid", 32'(bus.resp_valid), 32'd1);
        check("busy resp_rdata", bus.resp_rdata, 32'hFF017F80);
        @(negedge clk);
        check("after resp ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the WRITE state of an SB aborts without writing or responding.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h00000055;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort in write", 32'(bus.mem_write_en), 32'd1);
        rst = 1'b0;
        #1;
        check("abort we drop", 32'(bus.mem_write_en), 32'd0);
        check("abort resp", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) rv_seen++;
        end
        check("abort no resp", 32'(rv_seen), 32'd0);
        check("abort byte30", 32'(mem[8'h30]), 32'hA0);
        check("abort ready", 32'(bus.req_ready), 32'd1);

`ifdef LSU_STATS_EN
        check("cnt load rst", 32'(load_cnt), 32'd0);
        check("cnt store rst", 32'(store_cnt), 32'd0);
        check("cnt err rst", 32'(err_cnt), 32'd0);
        do_req(100, vecs[0]);
        do_req(101, vecs[9]);
        do_req(102, vecs[8]);
        do_req(103, vecs[10]);
        check("cnt load", 32'(load_cnt), 32'd2);
        check("cnt store", 32'(store_cnt), 32'd1);
        check("cnt err", 32'(err_cnt), 32'd1);
        force dut.store_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.store_cnt_q;
        sv = vecs[8];
        do_req(104, sv);
        check("cnt store sat", 32'(store_cnt), 32'hFFFF);
        check("cnt load after sat", 32'(load_cnt), 32'd2);
`else
        sv = vecs[0];
        do_req(100, sv);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
